// File: rtl/trigger_frame_gen_if.sv
// -----------------------------------------------------------------------------
// trigger_frame_gen_if
// 32-bit AXI-stream transmit bundle between the trigger frame generator and the
// ethernet MAC TX path.
//
// Handshake: a word transfers on a rising clk edge where TxValid=1 and
// TxReady=1. Once TxValid is raised, TxValid/TxData/TxStrb/TxLast hold steady
// until that transfer. TxReady is ignored while TxValid=0. TxLast marks the
// final word of a frame.
//
// Signals:
//   TxData  [31:0]  stream data        (master -> slave)
//   TxStrb  [3:0]   byte strobes       (master -> slave)
//   TxLast          final frame word   (master -> slave)
//   TxValid         word valid         (master -> slave)
//   TxReady         sink ready         (slave  -> master)
// -----------------------------------------------------------------------------
interface trigger_frame_gen_if;
  logic [31:0] TxData;
  logic [3:0]  TxStrb;
  logic        TxLast;
  logic        TxValid;
  logic        TxReady;

  modport master (
    output TxData,
    output TxStrb,
    output TxLast,
    output TxValid,
    input  TxReady
  );

  modport slave (
    input  TxData,
    input  TxStrb,
    input  TxLast,
    input  TxValid,
    output TxReady
  );
endinterface

// File: rtl/trigger_frame_gen.sv
// -----------------------------------------------------------------------------
// trigger_frame_gen
// Builds one trigger ethernet frame per accepted trigger request and streams it
// as 32-bit words: DstMac, SrcMac, ethertype, 48-bit tag, message, and (when
// PAD_EN=1) zero padding up to 15 words. A one-deep pending slot queues a
// trigger that arrives while a frame is in flight; further triggers are
// dropped and counted.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   Trigger            single-cycle trigger request
//   TriggerMessage     32-bit message, captured on acceptance
//   DstMac, SrcMac     48-bit MACs, captured on acceptance
//   tx                 AXI-stream master (TxData/TxStrb/TxLast/TxValid/TxReady)
//   Busy               frame in progress or pending (registered)
//   DropCount          saturating count of discarded triggers
//   dbg_state_o        current FSM state
// -----------------------------------------------------------------------------
module trigger_frame_gen #(
  parameter logic [15:0] ETHER_TYPE  = 16'h005c,
  parameter logic [47:0] TRIGGER_TAG = 48'h6e69_6769_7274,
  parameter bit          PAD_EN      = 1'b1,
  parameter int          DROP_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Trigger,
  input  logic [31:0]         TriggerMessage,
  input  logic [47:0]         DstMac,
  input  logic [47:0]         SrcMac,
  trigger_frame_gen_if.master tx,
  output logic                Busy,
  output logic [DROP_W-1:0]   DropCount,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_MESSAGE = 2'd2,
    ST_PAD     = 2'd3
  } state_e;

  localparam logic [3:0] LAST_IDX = PAD_EN ? 4'd14 : 4'd5;
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [3:0]          word_idx_q, word_idx_d;
  logic [47:0]         frame_dst_q, frame_dst_d;
  logic [47:0]         frame_src_q, frame_src_d;
  logic [31:0]         frame_msg_q, frame_msg_d;
  logic [47:0]         pend_dst_q, pend_src_q;
  logic [31:0]         pend_msg_q;
  logic                pending_q, pending_d;
  logic [DROP_W-1:0]   drop_q;
  logic                busy_q;
  logic [31:0]         tx_data_q, tx_data_d;
  logic [3:0]          tx_strb_q;
  logic                tx_last_q, tx_last_d;
  logic                tx_valid_q, tx_valid_d;

  logic hs, eof, trig_busy, pend_fill, pend_drop, load_frame, load_from_pend;

  function automatic logic [31:0] word_of(input logic [3:0]  idx,
                                          input logic [47:0] dst,
                                          input logic [47:0] src,
                                          input logic [31:0] msg);
    logic [31:0] w;
    w = 32'h0;
    case (idx)
      4'd0:    w = dst[31:0];
      4'd1:    w = {src[15:0], dst[47:32]};
      4'd2:    w = src[47:16];
      4'd3:    w = {TRIGGER_TAG[15:0], ETHER_TYPE};
      4'd4:    w = TRIGGER_TAG[47:16];
      4'd5:    w = msg;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  always_comb begin
    hs        = tx_valid_q & tx.TxReady;
    eof       = hs & tx_last_q;
    trig_busy = Trigger & (state_q != ST_IDLE);
    // A trigger on the last-word handshake with an empty slot goes straight
    // into the next frame instead of through the pending registers.
    pend_fill = trig_busy & ~pending_q & ~eof;
    pend_drop = trig_busy & pending_q;
    load_from_pend = eof & pending_q;
    load_frame = ((state_q == ST_IDLE) & Trigger) | (eof & (pending_q | Trigger));
    pending_d  = pend_fill | (pending_q & ~load_from_pend);

    state_d = state_q;
    if (load_frame) begin
      state_d = ST_HEADER;
    end else if (eof) begin
      state_d = ST_IDLE;
    end else if (hs) begin
      case (state_q)
        ST_HEADER:  if (word_idx_q == 4'd4) state_d = ST_MESSAGE;
        ST_MESSAGE: state_d = ST_PAD;
        default:    state_d = state_q;
      endcase
    end

    word_idx_d = word_idx_q;
    if (load_frame)  word_idx_d = 4'd0;
    else if (hs)     word_idx_d = word_idx_q + 4'd1;

    frame_dst_d = frame_dst_q;
    frame_src_d = frame_src_q;
    frame_msg_d = frame_msg_q;
    if (load_from_pend) begin
      frame_dst_d = pend_dst_q;
      frame_src_d = pend_src_q;
      frame_msg_d = pend_msg_q;
    end else if (load_frame) begin
      frame_dst_d = DstMac;
      frame_src_d = SrcMac;
      frame_msg_d = TriggerMessage;
    end

    // Output word is registered from next-state values, so it only moves on a
    // handshake or frame load and holds while stalled.
    tx_valid_d = (state_d != ST_IDLE);
    tx_data_d  = tx_valid_d ? word_of(word_idx_d, frame_dst_d, frame_src_d, frame_msg_d) : 32'h0;
    tx_last_d  = tx_valid_d & (word_idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= 4'd0;
      frame_dst_q <= 48'h0;
      frame_src_q <= 48'h0;
      frame_msg_q <= 32'h0;
      pend_dst_q  <= 48'h0;
      pend_src_q  <= 48'h0;
      pend_msg_q  <= 32'h0;
      pending_q   <= 1'b0;
      drop_q      <= '0;
      busy_q      <= 1'b0;
      tx_data_q   <= 32'h0;
      tx_strb_q   <= 4'h0;
      tx_last_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      frame_dst_q <= frame_dst_d;
      frame_src_q <= frame_src_d;
      frame_msg_q <= frame_msg_d;
      pending_q   <= pending_d;
      if (pend_fill) begin
        pend_dst_q <= DstMac;
        pend_src_q <= SrcMac;
        pend_msg_q <= TriggerMessage;
      end
      if (pend_drop && (drop_q != '1)) drop_q <= drop_q + DROP_ONE;
      busy_q     <= tx_valid_d | pending_d;
      tx_data_q  <= tx_data_d;
      tx_strb_q  <= tx_valid_d ? 4'hF : 4'h0;
      tx_last_q  <= tx_last_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx.TxData  = tx_data_q;
  assign tx.TxStrb  = tx_strb_q;
  assign tx.TxLast  = tx_last_q;
  assign tx.TxValid = tx_valid_q;
  assign Busy       = busy_q;
  assign DropCount  = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trigger_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_trigger_frame_gen
// Drives a padded (PAD_EN=1) and an unpadded (PAD_EN=0) generator from shared
// inputs. Each instance has a frame-queue reference model; directed table and
// hand-written sequences cover the listed corner cases, then random traffic.
// -----------------------------------------------------------------------------
module tb_trigger_frame_gen;

  localparam logic [47:0] TAG   = 48'h6e69_6769_7274;
  localparam logic [15:0] ETYPE = 16'h005c;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, trigger, ready;
  logic [31:0] msg;
  logic [47:0] dst, src;

  int tests = 0;
  int fails = 0;

  trigger_frame_gen_if u_if0 ();
  trigger_frame_gen_if u_if1 ();
  assign u_if0.TxReady = ready;
  assign u_if1.TxReady = ready;

  logic       busy0, busy1;
  logic [7:0] drop0, drop1;
  logic [1:0] dbg0, dbg1;

  trigger_frame_gen #(.PAD_EN(1'b1)) u_dut_pad (
    .clk(clk), .reset(reset), .Trigger(trigger), .TriggerMessage(msg),
    .DstMac(dst), .SrcMac(src), .tx(u_if0), .Busy(busy0), .DropCount(drop0),
    .dbg_state_o(dbg0)
  );

  trigger_frame_gen #(.PAD_EN(1'b0)) u_dut_nopad (
    .clk(clk), .reset(reset), .Trigger(trigger), .TriggerMessage(msg),
    .DstMac(dst), .SrcMac(src), .tx(u_if1), .Busy(busy1), .DropCount(drop1),
    .dbg_state_o(dbg1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame layout straight from the word table of the frame format.
  function automatic logic [31:0] frame_word(input int i, input logic [47:0] d,
                                             input logic [47:0] s, input logic [31:0] m);
    if (i == 0) return d[31:0];
    if (i == 1) return {s[15:0], d[47:32]};
    if (i == 2) return s[47:16];
    if (i == 3) return {TAG[15:0], ETYPE};
    if (i == 4) return TAG[47:16];
    if (i == 5) return m;
    return 32'h0;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] data_w[2];
  logic [3:0]  strb_w[2];
  logic        last_w[2], valid_w[2], busy_w[2];
  logic [7:0]  drop_w[2];
  assign data_w[0] = u_if0.TxData;  assign data_w[1] = u_if1.TxData;
  assign strb_w[0] = u_if0.TxStrb;  assign strb_w[1] = u_if1.TxStrb;
  assign last_w[0] = u_if0.TxLast;  assign last_w[1] = u_if1.TxLast;
  assign valid_w[0] = u_if0.TxValid; assign valid_w[1] = u_if1.TxValid;
  assign busy_w[0] = busy0; assign busy_w[1] = busy1;
  assign drop_w[0] = drop0; assign drop_w[1] = drop1;

  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int L = (g == 0) ? 15 : 6;
    logic [32:0] exp_q[$];   // {last, data} of every word still owed
    int          drops = 0;
    int          outstanding;
    bit          hs;

    always @(negedge clk) begin
      // compare state produced by the preceding rising edge
      check($sformatf("m%0d_valid", g), valid_w[g], exp_q.size() != 0);
      check($sformatf("m%0d_busy", g), busy_w[g], exp_q.size() != 0);
      check($sformatf("m%0d_drop", g), drop_w[g], drops);
      if (exp_q.size() != 0) begin
        check($sformatf("m%0d_data", g), data_w[g], exp_q[0][31:0]);
        check($sformatf("m%0d_last", g), last_w[g], exp_q[0][32]);
        check($sformatf("m%0d_strb", g), strb_w[g], 4'hF);
      end
      // advance to what the next rising edge should produce
      if (reset) begin
        exp_q.delete();
        drops = 0;
      end else begin
        outstanding = (exp_q.size() + L - 1) / L;   // frames not yet fully sent
        hs = (exp_q.size() != 0) && ready;
        if (trigger) begin
          if (outstanding < 2) begin
            for (int i = 0; i < L; i++)
              exp_q.push_back({(i == L - 1), frame_word(i, dst, src, msg)});
          end else if (drops < 255) begin
            drops++;
          end
        end
        if (hs) void'(exp_q.pop_front());
      end
    end
  end

  // Words actually transferred by each instance, for the directed checks.
  logic [32:0] got0[$];
  logic [32:0] got1[$];
  always @(negedge clk) begin
    if (!reset && ready) begin
      if (u_if0.TxValid === 1'b1) got0.push_back({u_if0.TxLast, u_if0.TxData});
      if (u_if1.TxValid === 1'b1) got1.push_back({u_if1.TxLast, u_if1.TxData});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; trigger = 1'b0;
    step();
    reset = 1'b0;
    got0.delete(); got1.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy0 || busy1) && n < 400) begin
      step();
      n++;
    end
    check({tag, "_idle_timeout"}, busy0 | busy1, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        trig;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;
  vec_t tbl[16];
  logic [31:0] ref_words[6];

  logic [47:0] d1;
  logic [31:0] m1;

  initial begin
    reset = 1'b1; trigger = 1'b0; ready = 1'b0;
    msg = 32'h0; dst = 48'h0; src = 48'h0;

    ref_words[0] = 32'h1111_6843; ref_words[1] = 32'h4502_1654;
    ref_words[2] = 32'h8f54_0000; ref_words[3] = 32'h7274_005c;
    ref_words[4] = 32'h6e69_6769; ref_words[5] = 32'hdead_beef;
    // row r: inputs applied, then outputs expected after the next edge
    tbl[0] = '{1'b1, 1'b0, 1'b1, ref_words[0], 1'b0};
    for (int r = 1; r < 15; r++)
      tbl[r] = '{1'b0, 1'b1, 1'b1, (r < 6) ? ref_words[r] : 32'h0, (r == 14)};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0};

    repeat (3) step();
    check("reset_valid", u_if0.TxValid, 1'b0);
    check("reset_last", u_if0.TxLast, 1'b0);
    check("reset_data", u_if0.TxData, 32'h0);
    check("reset_strb", u_if0.TxStrb, 4'h0);
    check("reset_busy", busy0, 1'b0);
    check("reset_drop", drop0, 8'h0);
    reset = 1'b0;
    step();

    // Frame 1: padded frame with TxReady held high
    dst = 48'h1654_1111_6843; src = 48'h8f54_0000_4502; msg = 32'hdead_beef;
    for (int r = 0; r < 16; r++) begin
      trigger = tbl[r].trig;
      ready   = tbl[r].rdy;
      step();
      check($sformatf("tbl%0d_valid", r), u_if0.TxValid, tbl[r].exp_valid);
      check($sformatf("tbl%0d_last", r), u_if0.TxLast, tbl[r].exp_last);
      if (tbl[r].exp_valid) check($sformatf("tbl%0d_data", r), u_if0.TxData, tbl[r].exp_data);
    end
    trigger = 1'b0;
    wait_idle("tbl");

    // Same frame with TxReady pattern 1,0,0,1 repeating
    do_reset();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 0; k < 60; k++) begin
      ready = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    ready = 1'b1;
    wait_idle("stall");
    check("stall_count", got0.size(), 15);
    for (int i = 0; i < 15; i++)
      check($sformatf("stall_w%0d", i), got0[i], {(i == 14), (i < 6) ? ref_words[i] : 32'h0});

    // PAD_EN=0: trigger at word 2 (pending), trigger at word 3 (dropped)
    do_reset();
    ready = 1'b1; msg = 32'hA; trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (2) step();
    msg = 32'h1; trigger = 1'b1;
    step();
    msg = 32'h2;
    step();
    trigger = 1'b0;
    wait_idle("pend");
    check("pend_count", got1.size(), 12);
    check("pend_f1_last", got1[5], {1'b1, 32'hA});
    check("pend_f2_last", got1[11], {1'b1, 32'h1});
    check("pend_drop1", drop1, 8'd1);
    check("pend_drop0", drop0, 8'd1);

    // Trigger coincident with last-word handshake of the unpadded instance
    do_reset();
    ready = 1'b1; msg = 32'h11; dst = 48'h0102_0304_0506; trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (5) step();
    check("coin_at_last", u_if1.TxLast, 1'b1);
    msg = 32'h22; dst = 48'hAABB_CCDD_EEFF; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("coin_no_bubble", u_if1.TxValid, 1'b1);
    wait_idle("coin");
    check("coin_count", got1.size(), 12);
    check("coin_f2_w0", got1[6], {1'b0, 32'hCCDD_EEFF});
    check("coin_f2_last", got1[11], {1'b1, 32'h22});
    check("coin_drop1", drop1, 8'd0);

    // Inputs change after acceptance, with stalls
    do_reset();
    d1 = 48'h1234_5678_9abc; m1 = 32'hCAFE_F00D;
    dst = d1; msg = m1; ready = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0; dst = 48'hFFFF_FFFF_FFFF; msg = 32'h0BAD_0BAD; src = 48'h5555_5555_5555;
    for (int k = 0; k < 40; k++) begin
      ready = ($urandom_range(0, 1) == 1);
      step();
    end
    ready = 1'b1;
    wait_idle("snap");
    check("snap_count", got0.size(), 15);
    check("snap_w0", got0[0][31:0], d1[31:0]);
    check("snap_msg", got0[5][31:0], m1);

    // Reset at word 7 abandons the frame
    do_reset();
    ready = 1'b1; dst = 48'h0000_1111_2222; trigger = 1'b1;
    step();
    step();
    step();
    trigger = 1'b0;
    repeat (5) step();
    check("rst_pre_drop", drop0, 8'd1);
    check("rst_pre_count", got0.size(), 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", u_if0.TxValid, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_drop", drop0, 8'd0);
    got0.delete();
    dst = 48'h0000_3333_4444; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("rst_new_w0", {u_if0.TxValid, u_if0.TxData}, {1'b1, 32'h3333_4444});
    wait_idle("rst");
    check("rst_new_count", got0.size(), 15);

    // DropCount saturation
    do_reset();
    ready = 1'b0; trigger = 1'b1;
    repeat (300) step();
    check("sat_drop0", drop0, 8'hFF);
    check("sat_drop1", drop1, 8'hFF);
    trigger = 1'b0; ready = 1'b1;
    wait_idle("sat");

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      trigger = ($urandom_range(0, 7) == 0);
      ready   = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 499) == 0);
      msg = $urandom;
      dst = {$urandom_range(0, 65535), $urandom};
      src = {$urandom_range(0, 65535), $urandom};
      step();
    end
    reset = 1'b0; trigger = 1'b0; ready = 1'b1;
    wait_idle("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
